fft_mag_streamer: RTL and testbench

// Sits between the FFT core's unload port and serial_peak_finder. Takes the complex FFT

---
 rtl/fft_mag_streamer_if.sv | 29 ++
 rtl/fft_mag_streamer.sv | 128 ++++++++++++
 tb/tb_fft_mag_streamer.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_mag_streamer_if.sv
// Bin stream between the FFT unload port, the magnitude streamer and the peak finder.
// The slave side is the streamer; the master side drives FFT bins and receives magnitudes.
interface fft_mag_streamer_if #(
   parameter int IN_W      = 16,
   parameter int FFT_IDX_W = 10,
   parameter int IDX_W     = 9
);
   logic signed [IN_W-1:0]   xk_re;
   logic signed [IN_W-1:0]   xk_im;
   logic [FFT_IDX_W-1:0]     xk_index;
   logic                     xk_dv;

   logic                     start;
   logic [2*IN_W-1:0]        data_out;
   logic [IDX_W-1:0]         index;
   logic                     valid;
   logic                     frame_done;
   logic                     frame_err;

   modport master (
      output xk_re, xk_im, xk_index, xk_dv,
      input  start, data_out, index, valid, frame_done, frame_err
   );

   modport slave (
      input  xk_re, xk_im, xk_index, xk_dv,
      output start, data_out, index, valid, frame_done, frame_err
   );
endinterface

// File: rtl/fft_mag_streamer.sv
// Converts FFT output bins to |X|^2 in a 2-stage pipeline and forwards bins 0..NUM_BINS-1
// framed with start/frame_done, flagging out-of-order delivery with frame_err.
module fft_mag_streamer #(
   parameter int IN_W      = 16,
   parameter int FFT_IDX_W = 10,
   parameter int IDX_W     = 9,
   parameter int NUM_BINS  = 512,
   parameter bit SKIP_DC   = 1'b1
) (
   input  logic               clk,
   input  logic               reset,
   fft_mag_streamer_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

   localparam logic [FFT_IDX_W-1:0] LAST_BIN   = FFT_IDX_W'(NUM_BINS - 1);
   localparam bit                   FULL_RANGE = (NUM_BINS == (1 << FFT_IDX_W));

   state_t                  state, state_nxt;
   logic [FFT_IDX_W-1:0]    expected, expected_nxt;
   logic                    accept, first, last, err;

   logic signed [2*IN_W-1:0] re_ext, im_ext;
   logic [2*IN_W-1:0]        sq_re, sq_im;

   logic [2*IN_W-1:0]       s1_sq_re, s1_sq_im;
   logic [IDX_W-1:0]        s1_idx;
   logic                    s1_vld, s1_first, s1_last, s1_err;

   // Sign-extend before squaring so the product is formed at full 2*IN_W width.
   assign re_ext = {{IN_W{bus.xk_re[IN_W-1]}}, bus.xk_re};
   assign im_ext = {{IN_W{bus.xk_im[IN_W-1]}}, bus.xk_im};
   assign sq_re  = re_ext * re_ext;
   assign sq_im  = im_ext * im_ext;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
      accept       = 1'b0;
      first        = 1'b0;
      err          = 1'b0;
      state_nxt    = state;
      expected_nxt = expected;
      if (bus.xk_dv) begin
         case (state)
            IDLE, DRAIN: begin
               if (bus.xk_index == '0) begin
                  accept = 1'b1;
                  first  = 1'b1;
               end
            end
            STREAM: begin
               if (bus.xk_index == expected) begin
                  accept = 1'b1;
               end else if (bus.xk_index == '0) begin
                  accept = 1'b1;
                  first  = 1'b1;
                  err    = 1'b1;
               end else begin
                  err       = 1'b1;
                  state_nxt = IDLE;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
      last = accept && (bus.xk_index == LAST_BIN);
      if (accept) begin
         if (last) begin
            state_nxt    = FULL_RANGE ? IDLE : DRAIN;
            expected_nxt = '0;
         end else begin
            state_nxt    = STREAM;
            expected_nxt = bus.xk_index + FFT_IDX_W'(1);
         end
      end
   end

   // Frame tracking and stage 1: squares plus the tags that travel with each bin.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         expected <= '0;
         s1_vld   <= 1'b0;
         s1_err   <= 1'b0;
         s1_first <= 1'b0;
         s1_last  <= 1'b0;
         s1_idx   <= '0;
         s1_sq_re <= '0;
         s1_sq_im <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
         state    <= state_nxt;
         expected <= expected_nxt;
         s1_vld   <= accept;
         s1_err   <= err;
         if (accept) begin
            s1_sq_re <= sq_re;
            s1_sq_im <= sq_im;
            s1_idx   <= bus.xk_index[IDX_W-1:0];
            s1_first <= first;
            s1_last  <= last;
         end
      end
   end

   // Stage 2: data_out/index hold through gaps so the peak finder only re-sees the old bin.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.valid      <= 1'b0;
         bus.start      <= 1'b0;
         bus.frame_done <= 1'b0;
         bus.frame_err  <= 1'b0;
         bus.data_out   <= '0;
         bus.index      <= '0;
      end else begin
         bus.valid      <= s1_vld;
         bus.start      <= s1_vld && s1_first;
         bus.frame_done <= s1_vld && s1_last;
         bus.frame_err  <= s1_err;
         if (s1_vld) begin
            bus.data_out <= (SKIP_DC && s1_first) ? '0 : (s1_sq_re + s1_sq_im);
            bus.index    <= s1_idx;
         end
      end
   end

endmodule

// File: tb/tb_fft_mag_streamer.sv
// Scoreboard bench for fft_mag_streamer: a frame-level reference model queues expected
// output events with their due cycle; a negedge monitor pops and compares them.
module tb_fft_mag_streamer;

   localparam int IN_W      = 16;
   localparam int FFT_IDX_W = 10;
   localparam int IDX_W     = 9;
   localparam int NUM_BINS  = 512;
   localparam int FFT_LEN   = 1 << FFT_IDX_W;

   typedef struct {
      int          cyc;
      bit          vld;
      bit          st;
      bit          dn;
      bit          er;
      logic [31:0] data;
      logic [8:0]  idx;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;

   exp_t        q[$];
   int          next_bin = -1;   // -1: waiting for bin 0 of a new frame
   logic [31:0] hold_data = '0;
   logic [8:0]  hold_idx = '0;
   logic [31:0] pk_val = '0;
   logic [8:0]  pk_idx = '0;

   fft_mag_streamer_if #(.IN_W(IN_W), .FFT_IDX_W(FFT_IDX_W), .IDX_W(IDX_W)) bus ();

   fft_mag_streamer #(
      .IN_W(IN_W), .FFT_IDX_W(FFT_IDX_W), .IDX_W(IDX_W), .NUM_BINS(NUM_BINS), .SKIP_DC(1'b1)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   // Drive one cycle of FFT output and queue whatever the frame rules say must appear.
   task automatic drive(input bit dv, input int idx, input int re, input int im);
      exp_t   e;
      longint mag;
      bus.xk_dv    = dv;
      bus.xk_index = idx[FFT_IDX_W-1:0];
      bus.xk_re    = re[IN_W-1:0];
      bus.xk_im    = im[IN_W-1:0];
      mag    = longint'(re) * re + longint'(im) * im;
      e.cyc  = cyc + 2;
      e.vld  = 1'b0;
      e.st   = 1'b0;
      e.dn   = 1'b0;
      e.er   = 1'b0;
      e.idx  = idx[8:0];
      e.data = (idx == 0) ? 32'd0 : mag[31:0];
      if (dv) begin
         if (idx == 0) begin
            e.er     = (next_bin > 0);
            e.vld    = 1'b1;
            e.st     = 1'b1;
            e.dn     = (NUM_BINS == 1);
            next_bin = e.dn ? -1 : 1;
         end else if (next_bin > 0 && idx == next_bin) begin
            e.vld    = 1'b1;
            e.dn     = (idx == NUM_BINS - 1);
            next_bin = e.dn ? -1 : idx + 1;
         end else if (next_bin > 0) begin
            e.er     = 1'b1;
            next_bin = -1;
         end
         if (e.vld || e.er) q.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   function automatic int rnd_s16();
      return int'($urandom_range(0, 65535)) - 32768;
   endfunction

   task automatic check_outputs_zero(input string tag);
      check({tag, "_valid"},      64'(bus.valid),      64'd0);
      check({tag, "_start"},      64'(bus.start),      64'd0);
      check({tag, "_frame_done"}, 64'(bus.frame_done), 64'd0);
      check({tag, "_frame_err"},  64'(bus.frame_err),  64'd0);
      check({tag, "_data_out"},   64'(bus.data_out),   64'd0);
      check({tag, "_index"},      64'(bus.index),      64'd0);
   endtask

   task automatic do_reset();
      bus.xk_dv = 1'b0;
      reset     = 1'b1;
      q.delete();
      next_bin  = -1;
      hold_data = '0;
      hold_idx  = '0;
      #1;
      check_outputs_zero("reset_async");
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;
   endtask

   // Monitor: compare every output event against the queue; on quiet cycles check the hold.
   always @(negedge clk) begin
      exp_t e;
      if (!reset) begin
         if (bus.valid || bus.frame_err) begin
            if (q.size() == 0) begin
               check("spurious_output", 64'(bus.valid | bus.frame_err), 64'd0);
            end else begin
               e = q.pop_front();
               check("output",
                     64'({bus.valid, bus.start, bus.frame_done, bus.frame_err, bus.index, bus.data_out}),
                     64'({e.vld, e.st, e.dn, e.er,
                          e.vld ? e.idx : hold_idx, e.vld ? e.data : hold_data}));
               check("latency", 64'(cyc), 64'(e.cyc));
               if (e.vld) begin
                  hold_data = e.data;
                  hold_idx  = e.idx;
               end
            end
            if (bus.valid) begin
               if (bus.start || bus.data_out > pk_val) begin
                  pk_val = bus.data_out;
                  pk_idx = bus.index;
               end
            end
         end else begin
            check("hold", 64'({bus.start, bus.frame_done, bus.index, bus.data_out}),
                  64'({2'b00, hold_idx, hold_data}));
            if (q.size() > 0 && q[0].cyc <= cyc) begin
               check("missing_output", 64'(bus.valid | bus.frame_err), 64'd1);
               void'(q.pop_front());
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete, %0d tests run", n_tests);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int gen;
      reset        = 1'b1;
      bus.xk_dv    = 1'b0;
      bus.xk_index = '0;
      bus.xk_re    = '0;
      bus.xk_im    = '0;
      repeat (3) @(posedge clk);
      #1;
      check_outputs_zero("reset_init");
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Full contiguous frame, 3-4j everywhere: 25 for bins 1..511, bins 512..1023 dropped.
      for (int i = 0; i < FFT_LEN; i++) drive(1'b1, i, 3, -4);
      repeat (3) drive(1'b0, 0, 0, 0);

      // Alternating gaps with an injected peak at bin 100.
      for (int i = 0; i < FFT_LEN; i++) begin
         if (i == 100) drive(1'b1, i, 1000, 0);
         else drive(1'b1, i, int'($urandom_range(0, 400)) - 200, int'($urandom_range(0, 400)) - 200);
         drive(1'b0, int'($urandom_range(0, FFT_LEN - 1)), rnd_s16(), rnd_s16());
      end
      repeat (3) drive(1'b0, 0, 0, 0);
      check("peak_index", 64'(pk_idx), 64'd100);
      check("peak_value", 64'(pk_val), 64'd1000000);

      // Extreme operands, then a reset while bins are still in the pipe.
      drive(1'b1, 0, -32768, -32768);
      drive(1'b1, 1, -32768, -32768);
      drive(1'b1, 2, 32767, 0);
      drive(1'b1, 3, -32768, 32767);
      drive(1'b1, 4, 0, -32768);
      drive(1'b1, 5, 11, 12);
      do_reset();

      // Pre-frame junk, then a partial frame.
      drive(1'b1, 7, 100, 100);
      drive(1'b1, 8, 100, 100);
      drive(1'b1, 9, 100, 100);
      for (int i = 0; i < 6; i++) drive(1'b1, i, i + 1, -i);
      repeat (4) drive(1'b0, 0, 0, 0);
      do_reset();

      // Out-of-order: 0,1,2,5 aborts; then 0,1,0 restarts with a second start.
      drive(1'b1, 0, 5, 5);
      drive(1'b1, 1, 6, 6);
      drive(1'b1, 2, 7, 7);
      drive(1'b1, 5, 8, 8);
      drive(1'b1, 6, 9, 9);
      drive(1'b0, 0, 0, 0);
      drive(1'b1, 0, 1, 2);
      drive(1'b1, 1, 3, 4);
      drive(1'b1, 0, 5, 6);
      drive(1'b1, 1, 7, 8);
      repeat (4) drive(1'b0, 0, 0, 0);

      // Randomised streams: gaps, occasional restarts and out-of-order indices, full-range data.
      gen = 0;
      for (int n = 0; n < 4000; n++) begin
         int r;
         r = int'($urandom_range(0, 999));
         if (r < 200) begin
            drive(1'b0, int'($urandom_range(0, FFT_LEN - 1)), rnd_s16(), rnd_s16());
         end else if (r < 210) begin
            drive(1'b1, int'($urandom_range(1, FFT_LEN - 1)), rnd_s16(), rnd_s16());
         end else if (r < 216) begin
            gen = 0;
            drive(1'b1, gen, rnd_s16(), rnd_s16());
            gen = gen + 1;
         end else begin
            drive(1'b1, gen, rnd_s16(), rnd_s16());
            gen = (gen + 1) % FFT_LEN;
         end
      end
      repeat (5) drive(1'b0, 0, 0, 0);
      check("queue_drained", 64'(q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
